vending_controller: RTL and testbench
=====================================

Name: vending_controller

Overview:
- Parametrised vending-machine core. It replaces the fixed 4-drink money counter with a full INSERT/DISPENSE/RETURN state machine.
- Supports N drinks with per-drink prices, a saturating credit limit, and paced change return.
- Sits between the debounced/one-pulsed button and keyboard front end and the seven-segment display and LED drivers.
- Pacing comes from an external one-cycle `tick` produced by the clock divider.

Parameters:
- MONEY_W, 8: credit register width.
- MAX_MONEY, 99: credit saturation value; must be < 2^MONEY_W.
- N_DRINKS, 4: number of selectable drinks.
- SEL_W, 2: width of drink select; 2^SEL_W >= N_DRINKS.
- PRICES, {8'd60,8'd30,8'd25,8'd20}: packed N_DRINKS*MONEY_W vector; drink i occupies bits [i*MONEY_W +: MONEY_W]. Default: drink0=20, drink1=25, drink2=30, drink3=60.
- COIN0, 5; COIN1, 10; COIN2, 50: coin values.
- RETURN_STEP, 5: largest change unit released per tick.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- tick  in  1  one-cycle pacing strobe.
- coin0, coin1, coin2  in  1 each  one-cycle coin-insert pulses.
- cancel  in  1  one-cycle cancel pulse.
- buy_req  in  1  one-cycle purchase request.
- buy_sel  in  SEL_W  drink index, sampled with buy_req.
- money  out  MONEY_W  current credit (registered).
- affordable  out  N_DRINKS  bit i = state is INSERT and money >= price[i] (combinational from registers).
- state_o  out  2  00 INSERT, 01 DISPENSE, 10 RETURN.
- dispense_valid  out  1  one-cycle pulse on accepted purchase.
- dispense_id  out  SEL_W  drink index; held until the next accepted purchase.
- buy_reject  out  1  one-cycle pulse on refused purchase.
- change_valid  out  1  one-cycle pulse per change unit released.
- change_amt  out  MONEY_W  value of the current change unit; valid with change_valid.

Behaviour:
- Reset:
  - state = INSERT, money = 0, dispense_id = 0.
  - dispense_valid, buy_reject, change_valid = 0; change_amt = 0.
  - rst overrides everything in any state, including mid-dispense or mid-return; undelivered change is discarded.
- INSERT state, per-cycle priority: cancel > buy_req > coin.
- cancel:
  - money != 0: go to RETURN next edge.
  - money == 0: stay in INSERT; no output.
  - Any coin or buy in the same cycle is dropped.
- buy_req:
  - Accept when buy_sel < N_DRINKS and money >= price[buy_sel].
  - On the accept edge: money <= money - price, dispense_id <= buy_sel, dispense_valid <= 1 for exactly one cycle, state <= DISPENSE.
  - Otherwise reject: buy_reject <= 1 for one cycle; money and state unchanged.
  - A coin in the same cycle is dropped.
- Coins:
  - Only one coin is credited per cycle, priority coin0 > coin1 > coin2; the others are dropped.
  - money <= min(money + coin, MAX_MONEY).
  - Compute the sum at MONEY_W+1 bits before saturating, so there is no wrap-around.
- tick has no effect in INSERT.
- DISPENSE state:
  - All inputs except rst and tick are ignored.
  - On the first tick: go to RETURN if money != 0, else INSERT.
  - Minimum dwell is 1 cycle; a tick on the cycle after entry counts.
- RETURN state:
  - All inputs except rst and tick are ignored.
  - Each tick: amt = min(RETURN_STEP, money); money <= money - amt; change_valid <= 1 for one cycle; change_amt <= amt.
  - If money - amt == 0, state <= INSERT on the same edge.
  - Total of all change_amt values equals the money value at RETURN entry.
- affordable is all-zero outside INSERT.
- Latency:
  - Input pulse to money/state update: 1 edge.
  - Input pulse to output pulse: 1 edge.
  - Pulses are never longer than one cycle, even if tick is held high. Each high cycle of tick counts as one tick.

Test Plan:
- Reset, then coin1 x3 and coin2 x1 → money 10, 20, 30, 80. Then coin2 → money 99 (saturated). affordable = 4'b1111.
- money 30, buy_req sel=2 → dispense_valid one cycle, dispense_id 2, money 0, state DISPENSE. Next tick → INSERT with no change pulses.
- money 45, buy_req sel=3 (price 60) → buy_reject one cycle; money stays 45; state stays INSERT. buy_sel beyond N_DRINKS (e.g. N_DRINKS=3, sel=3) → rejected.
- money 99, buy sel=0 → money 79. Over the following ticks: DISPENSE → RETURN, then 16 change_valid pulses (15x5 then 1x4), money reaches 0, state INSERT. Verify sum = 79.
- Same-cycle events:
  - coin0+coin2 → +5 only.
  - cancel+coin1 at money 20 → no credit; RETURN of 20.
  - coin during RETURN → ignored.
- rst mid-RETURN at money 35 → next cycle money 0, INSERT, no further change_valid pulses.

Source files
------------

// File: rtl/vending_controller.sv
// Vending-machine core: coin credit, drink purchase, paced change return.
// Three-state FSM (INSERT / DISPENSE / RETURN) paced by an external tick.
module vending_controller #(
    parameter int MONEY_W     = 8,
    parameter int MAX_MONEY   = 99,
    parameter int N_DRINKS    = 4,
    parameter int SEL_W       = 2,
    parameter logic [N_DRINKS*MONEY_W-1:0] PRICES =
        {8'd60, 8'd30, 8'd25, 8'd20},
    parameter int COIN0       = 5,
    parameter int COIN1       = 10,
    parameter int COIN2       = 50,
    parameter int RETURN_STEP = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tick,
    input  logic                coin0,
    input  logic                coin1,
    input  logic                coin2,
    input  logic                cancel,
    input  logic                buy_req,
    input  logic [SEL_W-1:0]    buy_sel,
    output logic [MONEY_W-1:0]  money,
    output logic [N_DRINKS-1:0] affordable,
    output logic [1:0]          state_o,
    output logic                dispense_valid,
    output logic [SEL_W-1:0]    dispense_id,
    output logic                buy_reject,
    output logic                change_valid,
    output logic [MONEY_W-1:0]  change_amt
);

    typedef enum logic [1:0] {
        S_INSERT   = 2'b00,
        S_DISPENSE = 2'b01,
        S_RETURN   = 2'b10
    } state_t;

    localparam logic [MONEY_W:0]   L_MAX = (MONEY_W+1)'(MAX_MONEY);
    localparam logic [MONEY_W:0]   L_C0  = (MONEY_W+1)'(COIN0);
    localparam logic [MONEY_W:0]   L_C1  = (MONEY_W+1)'(COIN1);
    localparam logic [MONEY_W:0]   L_C2  = (MONEY_W+1)'(COIN2);
    localparam logic [MONEY_W-1:0] L_RET = MONEY_W'(RETURN_STEP);

    state_t             r_state;
    logic [MONEY_W-1:0] r_money;
    logic [SEL_W-1:0]   r_id;
    logic               r_dv;
    logic               r_rej;
    logic               r_cv;
    logic [MONEY_W-1:0] r_camt;

    state_t             w_state_nx;
    logic [MONEY_W-1:0] w_money_nx;
    logic [SEL_W-1:0]   w_id_nx;
    logic               w_dv_nx;
    logic               w_rej_nx;
    logic               w_cv_nx;
    logic [MONEY_W-1:0] w_camt_nx;

    logic [MONEY_W:0]   w_coin;
    logic [MONEY_W:0]   w_sum;
    logic [MONEY_W-1:0] w_sat;
    logic [MONEY_W-1:0] w_price;
    logic [MONEY_W-1:0] w_amt;
    logic               w_any_coin;
    logic               w_sel_ok;
    logic               w_accept;

    // One coin per cycle; the sum is one bit wider so saturation never wraps
    always_comb begin
        w_coin = '0;
        if (coin0) begin
            w_coin = L_C0;
        end else if (coin1) begin
            w_coin = L_C1;
        end else if (coin2) begin
            w_coin = L_C2;
        end
    end

    assign w_any_coin = coin0 | coin1 | coin2;
    assign w_sum      = {1'b0, r_money} + w_coin;
    assign w_sat      = (w_sum > L_MAX) ? L_MAX[MONEY_W-1:0]
                                        : w_sum[MONEY_W-1:0];

    always_comb begin
        w_price = '0;
        for (int i = 0; i < N_DRINKS; i++) begin
            if (int'(buy_sel) == i) begin
                w_price = PRICES[i*MONEY_W +: MONEY_W];
            end
        end
    end

    assign w_sel_ok = int'(buy_sel) < N_DRINKS;
    assign w_accept = w_sel_ok && (r_money >= w_price);
    assign w_amt    = (r_money < L_RET) ? r_money : L_RET;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_INSERT;
            r_money <= '0;
            r_id    <= '0;
            r_dv    <= 1'b0;
            r_rej   <= 1'b0;
            r_cv    <= 1'b0;
            r_camt  <= '0;
        end else begin
            r_state <= w_state_nx;
            r_money <= w_money_nx;
            r_id    <= w_id_nx;
            r_dv    <= w_dv_nx;
            r_rej   <= w_rej_nx;
            r_cv    <= w_cv_nx;
            r_camt  <= w_camt_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_money_nx = r_money;
        w_id_nx    = r_id;
        w_dv_nx    = 1'b0;
        w_rej_nx   = 1'b0;
        w_cv_nx    = 1'b0;
        w_camt_nx  = '0;
        unique case (r_state)
            S_INSERT: begin
                if (cancel) begin
                    if (r_money != '0) begin
                        w_state_nx = S_RETURN;
                    end
                end else if (buy_req) begin
                    if (w_accept) begin
                        w_money_nx = r_money - w_price;
                        w_id_nx    = buy_sel;
                        w_dv_nx    = 1'b1;
                        w_state_nx = S_DISPENSE;
                    end else begin
                        w_rej_nx   = 1'b1;
                    end
                end else if (w_any_coin) begin
                    w_money_nx = w_sat;
                end
            end
            S_DISPENSE: begin
                if (tick) begin
                    w_state_nx = (r_money != '0) ? S_RETURN : S_INSERT;
                end
            end
            S_RETURN: begin
                if (tick) begin
                    w_money_nx = r_money - w_amt;
                    w_cv_nx    = 1'b1;
                    w_camt_nx  = w_amt;
                    if (r_money == w_amt) begin
                        w_state_nx = S_INSERT;
                    end
                end
            end
            default: w_state_nx = S_INSERT;
        endcase
    end

    always_comb begin
        affordable = '0;
        for (int i = 0; i < N_DRINKS; i++) begin
            affordable[i] = (r_state == S_INSERT) &&
                            (r_money >= PRICES[i*MONEY_W +: MONEY_W]);
        end
    end

    assign state_o        = r_state;
    assign money          = r_money;
    assign dispense_id    = r_id;
    assign dispense_valid = r_dv;
    assign buy_reject     = r_rej;
    assign change_valid   = r_cv;
    assign change_amt     = r_camt;

endmodule

// File: tb/tb_vending_controller.sv
// Bench for vending_controller: directed table, corner sequences and
// randomized traffic against an arithmetic reference model.
module tb_vending_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       coin0 = 1'b0, coin1 = 1'b0, coin2 = 1'b0;
    logic       cancel = 1'b0, buy_req = 1'b0;
    logic [1:0] buy_sel = 2'd0;

    logic [7:0] money, change_amt;
    logic [3:0] affordable;
    logic [1:0] state_o, dispense_id;
    logic       dispense_valid, buy_reject, change_valid;

    logic [7:0] money3, change_amt3;
    logic [2:0] affordable3;
    logic [1:0] state_o3, dispense_id3;
    logic       dispense_valid3, buy_reject3, change_valid3;

    always #5 clk = ~clk;

    vending_controller u_dut (
        .clk(clk), .rst(rst), .tick(tick),
        .coin0(coin0), .coin1(coin1), .coin2(coin2),
        .cancel(cancel), .buy_req(buy_req), .buy_sel(buy_sel),
        .money(money), .affordable(affordable), .state_o(state_o),
        .dispense_valid(dispense_valid), .dispense_id(dispense_id),
        .buy_reject(buy_reject), .change_valid(change_valid),
        .change_amt(change_amt)
    );

    // Three-drink variant: select 3 must be refused whatever the credit
    vending_controller #(
        .N_DRINKS(3),
        .PRICES({8'd30, 8'd25, 8'd20})
    ) u_dut3 (
        .clk(clk), .rst(rst), .tick(tick),
        .coin0(coin0), .coin1(coin1), .coin2(coin2),
        .cancel(cancel), .buy_req(buy_req), .buy_sel(buy_sel),
        .money(money3), .affordable(affordable3), .state_o(state_o3),
        .dispense_valid(dispense_valid3), .dispense_id(dispense_id3),
        .buy_reject(buy_reject3), .change_valid(change_valid3),
        .change_amt(change_amt3)
    );

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // Reference model: credit as a plain integer, state as 0/1/2
    int m_price[4] = '{20, 25, 30, 60};
    int m_coin[3]  = '{5, 10, 50};
    int m_money = 0, m_state = 0, m_id = 0, m_camt = 0;
    bit m_dv = 0, m_rej = 0, m_cv = 0;

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic void model_step(input bit r, t, c0, c1, c2, can, b,
                                       input int sel);
        m_dv = 0; m_rej = 0; m_cv = 0;
        if (r) begin
            m_money = 0; m_state = 0; m_id = 0; m_camt = 0;
            return;
        end
        if (m_state == 0) begin
            if (can) begin
                if (m_money > 0) m_state = 2;
            end else if (b) begin
                if (sel < 4 && m_money >= m_price[sel]) begin
                    m_money -= m_price[sel];
                    m_id = sel; m_dv = 1; m_state = 1;
                end else m_rej = 1;
            end else if (c0) m_money = imin(m_money + m_coin[0], 99);
            else if (c1) m_money = imin(m_money + m_coin[1], 99);
            else if (c2) m_money = imin(m_money + m_coin[2], 99);
        end else if (m_state == 1) begin
            if (t) m_state = (m_money != 0) ? 2 : 0;
        end else if (t) begin
            m_camt = imin(5, m_money);
            m_money -= m_camt;
            m_cv = 1;
            if (m_money == 0) m_state = 0;
        end
    endfunction

    function automatic int model_aff();
        int a = 0;
        if (m_state == 0)
            for (int i = 0; i < 4; i++)
                if (m_money >= m_price[i]) a |= (1 << i);
        return a;
    endfunction

    task automatic cyc(input bit r, t, c0, c1, c2, can, b, input int sel);
        rst = r; tick = t; coin0 = c0; coin1 = c1; coin2 = c2;
        cancel = can; buy_req = b; buy_sel = 2'(sel);
        @(posedge clk);
        model_step(r, t, c0, c1, c2, can, b, sel);
        #1;
        rst = 0; tick = 0; coin0 = 0; coin1 = 0; coin2 = 0;
        cancel = 0; buy_req = 0; buy_sel = 2'd0;
    endtask

    typedef struct {
        bit c0, c1, c2, can, b, t;
        int sel;
        int money, st, aff, dv, id, rej;
    } vec_t;

    vec_t tbl[14];
    int n, sum, last;
    bit done;

    initial begin
        // c0 c1 c2 can b t sel | money st aff dv id rej
        tbl[0]  = '{0,1,0,0,0,0,0, 10,0, 0,0,0,0};
        tbl[1]  = '{0,1,0,0,0,0,0, 20,0, 1,0,0,0};
        tbl[2]  = '{0,1,0,0,0,0,0, 30,0, 7,0,0,0};
        tbl[3]  = '{0,0,0,0,1,0,2,  0,1, 0,1,2,0};
        tbl[4]  = '{0,0,0,0,0,1,0,  0,0, 0,0,2,0};
        tbl[5]  = '{0,0,1,0,0,0,0, 50,0, 7,0,2,0};
        tbl[6]  = '{0,0,0,0,1,0,3, 50,0, 7,0,2,1};
        tbl[7]  = '{1,0,1,0,0,0,0, 55,0, 7,0,2,0};
        tbl[8]  = '{0,1,0,0,0,0,0, 65,0,15,0,2,0};
        tbl[9]  = '{0,0,1,0,0,0,0, 99,0,15,0,2,0};
        tbl[10] = '{0,0,0,0,1,0,0, 79,1, 0,1,0,0};
        tbl[11] = '{0,0,1,0,0,0,0, 79,1, 0,0,0,0};
        tbl[12] = '{0,0,0,0,0,1,0, 79,2, 0,0,0,0};
        tbl[13] = '{0,1,0,1,1,0,1, 79,2, 0,0,0,0};

        cyc(1,0,0,0,0,0,0,0);
        cyc(1,0,0,0,0,0,0,0);
        chk("rst_money", money, 0);
        chk("rst_state", state_o, 0);
        chk("rst_id", dispense_id, 0);
        chk("rst_dv", dispense_valid, 0);
        chk("rst_rej", buy_reject, 0);
        chk("rst_cv", change_valid, 0);
        chk("rst_camt", change_amt, 0);
        chk("rst_aff", affordable, 0);

        foreach (tbl[k]) begin
            cyc(0, tbl[k].t, tbl[k].c0, tbl[k].c1, tbl[k].c2,
                tbl[k].can, tbl[k].b, tbl[k].sel);
            chk($sformatf("v%0d_money", k), money, tbl[k].money);
            chk($sformatf("v%0d_state", k), state_o, tbl[k].st);
            chk($sformatf("v%0d_aff", k), affordable, tbl[k].aff);
            chk($sformatf("v%0d_dv", k), dispense_valid, tbl[k].dv);
            chk($sformatf("v%0d_id", k), dispense_id, tbl[k].id);
            chk($sformatf("v%0d_rej", k), buy_reject, tbl[k].rej);
            chk($sformatf("v%0d_cv", k), change_valid, 0);
            chk($sformatf("v%0d_m3", k), money3, tbl[k].money);
        end

        // Drain 79 with tick every other cycle and a coin thrown in
        n = 0; sum = 0; last = 0; done = 0;
        for (int i = 0; i < 60; i++) begin
            cyc(0, (i % 2 == 0), 0, (i == 0), 0, 0, 0, 0);
            chk("drain_pace", change_valid, int'(i % 2 == 0));
            if (change_valid) begin
                n++; sum += change_amt; last = change_amt;
            end
            if (state_o == 2'd0) begin
                done = 1;
                break;
            end
        end
        chk("drain_done", done, 1);
        chk("drain_pulses", n, 16);
        chk("drain_sum", sum, 79);
        chk("drain_last", last, 4);
        chk("drain_money", money, 0);

        // Cancel with a coin in the same cycle; tick held high
        cyc(0,0,0,1,0,0,0,0);
        cyc(0,0,0,1,0,0,0,0);
        cyc(0,0,0,1,0,1,0,0);
        chk("cancel_money", money, 20);
        chk("cancel_state", state_o, 2);
        n = 0; sum = 0; done = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(0,1,0,0,0,0,0,0);
            chk("held_tick_cv", change_valid, 1);
            if (change_valid) begin
                n++; sum += change_amt;
            end
            if (state_o == 2'd0) begin
                done = 1;
                break;
            end
        end
        chk("cancel_done", done, 1);
        chk("cancel_pulses", n, 4);
        chk("cancel_sum", sum, 20);

        // Select 3 accepted by 4-drink core, refused by 3-drink core
        cyc(0,0,0,0,1,0,0,0);
        cyc(0,0,0,0,1,0,0,0);
        cyc(0,0,0,0,0,0,1,3);
        chk("sel3_money", money, 39);
        chk("sel3_dv", dispense_valid, 1);
        chk("sel3_id", dispense_id, 3);
        chk("sel3_state", state_o, 1);
        chk("n3_rej", buy_reject3, 1);
        chk("n3_dv", dispense_valid3, 0);
        chk("n3_money", money3, 99);
        chk("n3_state", state_o3, 0);
        cyc(1,0,0,0,0,0,0,0);
        chk("rst_disp_money", money, 0);
        chk("rst_disp_state", state_o, 0);
        chk("rst_disp_m3", money3, 0);

        // Reset in the middle of a return at 35
        cyc(0,0,0,1,0,0,0,0);
        cyc(0,0,0,1,0,0,0,0);
        cyc(0,0,0,1,0,0,0,0);
        cyc(0,0,1,0,0,0,0,0);
        cyc(0,0,0,0,0,1,0,0);
        chk("ret35_money", money, 35);
        chk("ret35_state", state_o, 2);
        cyc(0,1,0,0,0,0,0,0);
        chk("ret35_cv", change_valid, 1);
        chk("ret35_after", money, 30);
        cyc(1,1,0,0,0,0,0,0);
        chk("rst_ret_money", money, 0);
        chk("rst_ret_state", state_o, 0);
        chk("rst_ret_cv", change_valid, 0);
        for (int i = 0; i < 4; i++) begin
            cyc(0,1,0,0,0,0,0,0);
            chk("post_rst_cv", change_valid, 0);
            chk("post_rst_money", money, 0);
        end

        // Randomized traffic against the model
        for (int i = 0; i < 800; i++) begin
            cyc(($urandom_range(0, 149) == 0),
                ($urandom_range(0, 2) == 0),
                ($urandom_range(0, 5) == 0),
                ($urandom_range(0, 4) == 0),
                ($urandom_range(0, 7) == 0),
                ($urandom_range(0, 24) == 0),
                ($urandom_range(0, 5) == 0),
                int'($urandom_range(0, 3)));
            chk("rnd_money", money, m_money);
            chk("rnd_state", state_o, m_state);
            chk("rnd_aff", affordable, model_aff());
            chk("rnd_dv", dispense_valid, m_dv);
            chk("rnd_id", dispense_id, m_id);
            chk("rnd_rej", buy_reject, m_rej);
            chk("rnd_cv", change_valid, m_cv);
            if (m_cv) chk("rnd_camt", change_amt, m_camt);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
